// File: rtl/ccc_pkg.sv
// Shared constants for the capture/compare block: flag bit positions and
// default data/address widths used by the capture stage, this buffer and
// the bus wrapper.
package ccc_pkg;

  localparam int CCC_DW     = 16;
  localparam int CCC_AW     = 4;
  localparam int CCC_NFLAGS = 4;

  localparam int CCC_FLAG_CAP   = 0;
  localparam int CCC_FLAG_MATCH = 1;
  localparam int CCC_FLAG_LEVEL = 2;
  localparam int CCC_FLAG_OVF   = 3;

  // Assemble a flag vector so callers never hard-code bit positions.
  function automatic logic [CCC_NFLAGS-1:0] ccc_flag_vec(
    input logic cap,
    input logic match,
    input logic lvl,
    input logic ovf
  );
    logic [CCC_NFLAGS-1:0] v;
    v                 = '0;
    v[CCC_FLAG_CAP]   = cap;
    v[CCC_FLAG_MATCH] = match;
    v[CCC_FLAG_LEVEL] = lvl;
    v[CCC_FLAG_OVF]   = ovf;
    return v;
  endfunction

endpackage

// File: rtl/ccc_fifo_core.sv
// First-word-fall-through FIFO: AW-bit wrapping pointers, separate AW+1-bit
// level counter, flush overriding push/pop. Storage is not reset; the head
// output is forced to zero while empty.
module ccc_fifo_core #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic [AW:0]   level_o,
  output logic [AW:0]   level_nxt_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_ok, pop_ok;

  assign empty_o     = (level_q == '0);
  assign full_o      = (level_q == FULL_LVL);
  assign level_o     = level_q;
  assign level_nxt_o = level_d;
  assign rdata_o     = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when a pop frees the head slot.
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  // Next-state pointers and level; flush wins over any same-cycle traffic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; a flushed push never lands.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ccc_capture_fifo.sv
// Capture buffer + interrupt stage. Queues capture values in a FWFT FIFO and
// raises CAP / MATCH / LEVEL / OVF raw flags, cleared by write-one pulses
// (set beats clear), masked into mis and reduced onto irq.
module ccc_capture_fifo
  import ccc_pkg::*;
#(
  parameter int DW = CCC_DW,
  parameter int AW = CCC_AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap_done,
  input  logic [DW-1:0]         capture,
  input  logic                  cntr_match,
  input  logic                  rd,
  input  logic                  flush,
  input  logic [AW:0]           threshold,
  input  logic [CCC_NFLAGS-1:0] im,
  input  logic [CCC_NFLAGS-1:0] icr,
  output logic [DW-1:0]         rdata,
  output logic [AW:0]           level,
  output logic                  empty,
  output logic                  full,
  output logic [CCC_NFLAGS-1:0] ris,
  output logic [CCC_NFLAGS-1:0] mis,
  output logic                  irq
);

  logic [AW:0]           level_nxt;
  logic                  match_q;
  logic [CCC_NFLAGS-1:0] ris_q, ris_d;
  logic [CCC_NFLAGS-1:0] flag_set;
  logic                  match_rise, lvl_cross, drop;

  ccc_fifo_core #(
    .DW (DW),
    .AW (AW)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (cap_done),
    .pop_i       (rd),
    .flush_i     (flush),
    .wdata_i     (capture),
    .rdata_o     (rdata),
    .level_o     (level),
    .level_nxt_o (level_nxt),
    .empty_o     (empty),
    .full_o      (full)
  );

  // Event detection. Drop is judged on occupancy alone so flush never
  // alters flag behaviour; LEVEL uses the next level so it lands together
  // with the level update.
  always_comb begin
    match_rise = cntr_match & ~match_q;
    drop       = cap_done & full & ~rd;
    lvl_cross  = (threshold != '0) && (level < threshold) && (level_nxt >= threshold);
    flag_set   = ccc_flag_vec(cap_done, match_rise, lvl_cross, drop);
    ris_d      = (ris_q & ~icr) | flag_set;
  end

  // Edge register resets high so a counter sitting at its compare value
  // out of reset does not look like a fresh match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) match_q <= 1'b1;
    else        match_q <= cntr_match;
  end

  // Raw interrupt flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ris_q <= '0;
    else        ris_q <= ris_d;
  end

  assign ris = ris_q;
  assign mis = ris_q & im;
  assign irq = |mis;

endmodule

// File: tb/tb_ccc_capture_fifo.sv
// Bench for ccc_capture_fifo: queue-based reference model updated with each
// driven cycle, a per-cycle compare process, directed scenarios with literal
// expectations, then randomized traffic.
module tb_ccc_capture_fifo;
  import ccc_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cap_done;
  logic [DW-1:0] capture;
  logic          cntr_match;
  logic          rd;
  logic          flush;
  logic [AW:0]   threshold;
  logic [3:0]    im;
  logic [3:0]    icr;
  logic [DW-1:0] rdata;
  logic [AW:0]   level;
  logic          empty;
  logic          full;
  logic [3:0]    ris;
  logic [3:0]    mis;
  logic          irq;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // reference model state
  logic [DW-1:0] mq[$];
  logic [3:0]    m_ris;
  logic          m_prev;

  ccc_capture_fifo #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_done   (cap_done),
    .capture    (capture),
    .cntr_match (cntr_match),
    .rd         (rd),
    .flush      (flush),
    .threshold  (threshold),
    .im         (im),
    .icr        (icr),
    .rdata      (rdata),
    .level      (level),
    .empty      (empty),
    .full       (full),
    .ris        (ris),
    .mis        (mis),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ris  = 4'h0;
    m_prev = 1'b1;
  endtask

  // Apply the currently driven inputs to the model as one clock edge.
  task automatic model_step();
    int         old;
    bit         pop, push, drop;
    logic [3:0] set;
    old  = mq.size();
    set  = 4'h0;
    drop = cap_done && (old == DEPTH) && !rd;
    set[0] = cap_done;
    set[1] = cntr_match && !m_prev;
    m_prev = cntr_match;
    set[3] = drop;
    if (flush) begin
      mq.delete();
    end else begin
      pop  = rd && (old > 0);
      push = cap_done && ((old < DEPTH) || rd);
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(capture);
    end
    set[2] = (threshold != 0) && (old < int'(threshold)) && (mq.size() >= int'(threshold));
    m_ris  = (m_ris & ~icr) | set;
  endtask

  // Drive one cycle, advance the model, then wait until past the next edge.
  task automatic step(input bit c, input logic [DW-1:0] d, input bit r, input bit f,
                      input logic [3:0] ic);
    cap_done = c;
    capture  = d;
    rd       = r;
    flush    = f;
    icr      = ic;
    model_step();
    @(negedge clk);
    #1;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      cmp("level", level, mq.size());
      cmp("empty", empty, mq.size() == 0);
      cmp("full",  full,  mq.size() == DEPTH);
      cmp("rdata", rdata, (mq.size() > 0) ? mq[0] : 16'h0);
      cmp("ris",   ris,   m_ris);
      cmp("mis",   mis,   m_ris & im);
      cmp("irq",   irq,   |(m_ris & im));
    end
  end

  initial begin
    bit         c, r, f;
    logic [3:0] ic;

    rst_n = 1'b0; cap_done = 1'b0; capture = '0; cntr_match = 1'b1;
    rd = 1'b0; flush = 1'b0; threshold = '0; im = 4'h0; icr = 4'h0;
    model_reset();
    @(negedge clk); #1;
    check_en = 1'b1;
    @(negedge clk); #1;
    cmp("rst_level", level, 0);
    cmp("rst_empty", empty, 1);
    cmp("rst_rdata", rdata, 0);
    cmp("rst_irq",   irq,   0);
    rst_n = 1'b1;

    // basic push/pop, match held high from reset
    step(1, 16'h1234, 0, 0, 4'h0);
    step(1, 16'hABCD, 0, 0, 4'h0);
    cmp("two_level", level, 2);
    cmp("two_rdata", rdata, 16'h1234);
    cmp("two_cap",   ris[0], 1);
    cmp("held_match", ris[1], 0);
    step(0, 0, 1, 0, 4'h0);
    cmp("pop_rdata", rdata, 16'hABCD);
    cmp("pop_level", level, 1);
    step(0, 0, 1, 0, 4'h0);
    step(0, 0, 1, 0, 4'h0);
    cmp("rd_empty_ovf", ris[3], 0);

    // match edge detection and set-beats-clear
    cntr_match = 1'b0; step(0, 0, 0, 0, 4'h0);
    cmp("fall_match", ris[1], 0);
    cntr_match = 1'b1; step(0, 0, 0, 0, 4'h0);
    cmp("rise_match", ris[1], 1);
    cntr_match = 1'b0; step(0, 0, 0, 0, 4'b0010);
    cmp("clr_match", ris[1], 0);
    cntr_match = 1'b1; step(0, 0, 0, 0, 4'b0010);
    cmp("setwins_match", ris[1], 1);
    step(0, 0, 0, 0, 4'hF);
    cmp("clr_all", ris, 0);

    // fill past full
    for (int i = 0; i < 17; i++) step(1, 16'hC000 + 16'(i), 0, 0, 4'h0);
    cmp("fill_full",  full,  1);
    cmp("fill_level", level, 16);
    cmp("fill_ovf",   ris[3], 1);
    cmp("fill_head",  rdata, 16'hC000);
    step(0, 0, 0, 0, 4'hF);
    step(1, 16'hBEEF, 1, 0, 4'h0);
    cmp("pp_level", level, 16);
    cmp("pp_ovf",   ris[3], 0);
    for (int i = 1; i < 16; i++) begin
      cmp("drain", rdata, 32'hC000 + 32'(i));
      step(0, 0, 1, 0, 4'h0);
    end
    cmp("drain_last", rdata, 16'hBEEF);
    step(0, 0, 1, 0, 4'h0);
    cmp("drain_empty", empty, 1);

    // level threshold interrupt
    step(0, 0, 0, 0, 4'hF);
    threshold = 5'd3; im = 4'b0100;
    step(1, 16'h0001, 0, 0, 4'h0);
    step(1, 16'h0002, 0, 0, 4'h0);
    cmp("thr_below_irq", irq, 0);
    step(1, 16'h0003, 0, 0, 4'h0);
    cmp("thr_lvl", ris[2], 1);
    cmp("thr_irq", irq, 1);
    step(0, 0, 0, 0, 4'b0100);
    cmp("thr_clr", ris[2], 0);
    step(1, 16'h0004, 0, 0, 4'h0);
    cmp("thr_noreset", ris[2], 0);
    cmp("thr_level4", level, 4);

    // flush with a same-cycle push
    step(0, 0, 0, 1, 4'hF);
    threshold = '0; im = 4'h0;
    for (int i = 0; i < 5; i++) step(1, 16'h0100 + 16'(i), 0, 0, 4'h0);
    cmp("pre_flush_level", level, 5);
    step(1, 16'h0777, 0, 1, 4'h0);
    cmp("fl_level", level, 0);
    cmp("fl_empty", empty, 1);
    cmp("fl_rdata", rdata, 0);
    cmp("fl_cap",   ris[0], 1);
    cmp("fl_ovf",   ris[3], 0);

    // asynchronous reset mid-operation
    step(1, 16'h1111, 0, 0, 4'h0);
    step(1, 16'h2222, 0, 0, 4'h0);
    step(0, 0, 1, 0, 4'h0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp("arst_level", level, 0);
    cmp("arst_empty", empty, 1);
    cmp("arst_rdata", rdata, 0);
    cmp("arst_ris",   ris,   0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    step(1, 16'h5555, 0, 0, 4'h0);
    cmp("post_rst_rdata", rdata, 16'h5555);
    cmp("post_rst_level", level, 1);

    // randomized traffic, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) threshold = 5'($urandom_range(0, 17));
      if ($urandom_range(0, 7) == 0)  im = 4'($urandom);
      if ($urandom_range(0, 3) == 0)  cntr_match = ~cntr_match;
      if (((i / 200) % 2) == 0) begin
        c = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        c = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      f  = ($urandom_range(0, 63) == 0);
      ic = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      if (f && c && !r && (mq.size() == DEPTH)) c = 1'b0;
      step(c, 16'($urandom), r, f, ic);
    end

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccc_capture_fifo.md
# ccc_capture_fifo

Capture buffer and interrupt stage that sits directly downstream of the 16-bit capture/compare counter. It queues every capture value presented with `cap_done` into a first-word-fall-through FIFO and detects counter-match edges. It raises maskable interrupt flags for capture, match, level-threshold and overflow events, so software can drain captures in bursts without losing samples.

## Interface
- `DW`, 16, capture data width
- `AW`, 4, FIFO address width; depth = 2^AW
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cap_done`  in  1  one-cycle push strobe from the capture stage
- `capture`  in  DW  capture value, sampled when `cap_done`=1
- `cntr_match`  in  1  level compare-match from the counter stage
- `rd`  in  1  one-cycle pop strobe
- `flush`  in  1  one-cycle FIFO clear
- `threshold`  in  AW+1  level-interrupt threshold
- `im`  in  4  interrupt mask
- `icr`  in  4  write-one-to-clear pulses for `ris`
- `rdata`  out  DW  head entry, valid while `empty`=0
- `level`  out  AW+1  entries held, 0..2^AW
- `empty`  out  1  level==0
- `full`  out  1  level==2^AW
- `ris`  out  4  raw flags: [0] CAP, [1] MATCH, [2] LEVEL, [3] OVF
- `mis`  out  4  `ris & im`
- `irq`  out  1  `|mis`

## Operation
- Push when `cap_done` and (not `full` or `rd`). Pop when `rd` and not `empty`. Both may occur in one cycle; `level` is then unchanged.
- Full with push, no pop: sample dropped, stored data untouched, OVF set.
- `rd` while empty: ignored, no flag.
- `flush` has highest priority. Pointers and `level` go to 0, and any same-cycle push and pop are discarded. Flags are not changed by `flush`.
- Pointers are AW bits and wrap modulo 2^AW. `level` is a separate AW+1-bit counter.
- CAP is set on every `cap_done`, including dropped ones.
- MATCH is set on a 0→1 edge of `cntr_match`. The edge register resets to 1, so no flag is raised out of reset when counter and compare are both 0.
- LEVEL is set on the cycle `level` transitions from below `threshold` to at-or-above it. `threshold`=0 never sets LEVEL.
- OVF is set on every dropped push.
- Each `ris` bit is cleared by the matching `icr` bit. If set and clear coincide, set wins.
- Reset values: `ris`, `mis`, `irq`, `level`, `full` = 0; `empty` = 1; `rdata` = 0 (storage reset is not required, but `rdata` is forced to 0 while empty).

## Timing
- `cap_done` at cycle N: `level`, `empty`, `rdata` and CAP update at N+1. `irq` is combinational from registered `ris`, so it also asserts at N+1.
- `rd` at N: next entry on `rdata` and decremented `level` at N+1.
- `cntr_match` rising at N: MATCH at N+1.
- `icr` at N: bit reads 0 at N+1 unless re-set at N.
- Reset asserted mid-operation clears everything asynchronously. The first push after release lands in entry 0.

## Structure
- Shared package holds the flag index constants (`CCC_FLAG_CAP`=0, `CCC_FLAG_MATCH`=1, `CCC_FLAG_LEVEL`=2, `CCC_FLAG_OVF`=3) and the default `DW`/`AW`. The capture stage and the bus wrapper use the same package.
- One sub-module: `ccc_fifo_core`, a parameterised FWFT FIFO with push, pop, flush, level, empty and full.
  - It contains no flag logic.
  - Flag, edge-detect and mask logic stay in the top.

## Test plan
- Reset, then push 0x1234, 0xABCD: `level`=2 at N+1 of the second push, `rdata`=0x1234; `rd` → `rdata`=0xABCD, `level`=1; CAP set.
- Push 17 values with AW=4: first 16 stored and read back in order, 17th dropped, OVF=1, `full`=1, `level`=16.
- With `full`=1, assert `cap_done` and `rd` in the same cycle: `level` stays 16, new value appears last, no OVF.
- `threshold`=3, `im`=4'b0100: third push sets LEVEL and `irq`=1 at N+1; `icr`=4'b0100 clears it; a fourth push does not re-set LEVEL.
- Hold `cntr_match`=1 from reset: MATCH stays 0. Drop it to 0, then raise it: MATCH=1 one cycle after the rise. `icr` bit 1 together with a new rising edge: MATCH stays 1.
- Fill to 5 entries, then assert `flush` with `cap_done` in the same cycle: `level`=0, `empty`=1, `rdata`=0, CAP set, OVF unchanged.
